// File: rtl/timer_pkg.sv
// Shared encodings and constants for the tick timebase and timer channels.
package timer_pkg;
   localparam int US_PER_MS = 1000;
   localparam int MS_PER_S  = 1000;

   localparam logic ONE_SHOT = 1'b0;
   localparam logic PERIODIC = 1'b1;
   localparam logic BASE_US  = 1'b0;
   localparam logic BASE_MS  = 1'b1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;
endpackage

// File: rtl/timer_channel.sv
// One programmable down-counting timer: latches mode/base/period on start,
// counts selected-base ticks and pulses expire one cycle after the terminal tick.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             iClk,
   input  logic             resetn_i,
   input  logic             tick_us_i,
   input  logic             tick_ms_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             mode_i,
   input  logic             base_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             busy_o,
   output logic             expire_o
);
   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             base_q, base_d;
   logic             expire_q, expire_d;
   logic             sel_tick;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      period_d = period_q;
      mode_d   = mode_q;
      base_d   = base_q;
      expire_d = 1'b0;
      sel_tick = (base_q == BASE_MS) ? tick_ms_i : tick_us_i;
      // stop beats start and a terminal tick; a tick coinciding with start is dropped
      if (stop_i) begin
         state_d = IDLE;
      end else if (start_i && (period_i != '0)) begin
         state_d  = RUN;
         mode_d   = mode_i;
         base_d   = base_i;
         period_d = period_i;
         count_d  = period_i;
      end else if ((state_q == RUN) && sel_tick) begin
         if (count_q == CNT_W'(1)) begin
            expire_d = 1'b1;
            if (mode_q == PERIODIC) count_d = period_q;
            else                    state_d = IDLE;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= IDLE;
         count_q  <= '0;
         period_q <= '0;
         mode_q   <= ONE_SHOT;
         base_q   <= BASE_US;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         base_q   <= base_d;
         expire_q <= expire_d;
      end
   end

   assign busy_o   = (state_q == RUN);
   assign expire_o = expire_q;
endmodule

// File: rtl/tick_timer_array.sv
// Aligned 1us/1ms/1s strobe generator feeding NUM_CH independent timer channels.
module tick_timer_array
   import timer_pkg::*;
#(
   parameter int CLK_PER_US = 24,
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 16
) (
   input  logic                    iClk,
   input  logic                    resetn_i,
   output logic                    tick_1us_o,
   output logic                    tick_1ms_o,
   output logic                    tick_1s_o,
   input  logic [NUM_CH-1:0]       ch_start_i,
   input  logic [NUM_CH-1:0]       ch_stop_i,
   input  logic [NUM_CH-1:0]       ch_mode_i,
   input  logic [NUM_CH-1:0]       ch_base_i,
   input  logic [NUM_CH*CNT_W-1:0] ch_period_i,
   output logic [NUM_CH-1:0]       ch_busy_o,
   output logic [NUM_CH-1:0]       ch_expire_o
);
   localparam int PRE_W = $clog2(CLK_PER_US);
   localparam int MS_W  = $clog2(US_PER_MS);
   localparam int S_W   = $clog2(MS_PER_S);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
   logic [S_W-1:0]   s_cnt_q, s_cnt_d;
   logic             tick_us_q, tick_us_d;
   logic             tick_ms_q, tick_ms_d;
   logic             tick_s_q, tick_s_d;
   logic             us_wrap, ms_wrap, s_wrap;

   // wraps are qualified by the lower wrap so the registered strobes nest
   always_comb begin
      us_wrap   = (pre_q == PRE_W'(CLK_PER_US - 1));
      ms_wrap   = us_wrap && (ms_cnt_q == MS_W'(US_PER_MS - 1));
      s_wrap    = ms_wrap && (s_cnt_q == S_W'(MS_PER_S - 1));
      pre_d     = us_wrap ? '0 : pre_q + 1'b1;
      ms_cnt_d  = ms_cnt_q;
      s_cnt_d   = s_cnt_q;
      if (us_wrap) ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + 1'b1;
      if (ms_wrap) s_cnt_d  = s_wrap  ? '0 : s_cnt_q + 1'b1;
      tick_us_d = us_wrap;
      tick_ms_d = ms_wrap;
      tick_s_d  = s_wrap;
   end

   always_ff @(posedge iClk or negedge resetn_i) begin
      if (!resetn_i) begin
         pre_q     <= '0;
         ms_cnt_q  <= '0;
         s_cnt_q   <= '0;
         tick_us_q <= 1'b0;
         tick_ms_q <= 1'b0;
         tick_s_q  <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         ms_cnt_q  <= ms_cnt_d;
         s_cnt_q   <= s_cnt_d;
         tick_us_q <= tick_us_d;
         tick_ms_q <= tick_ms_d;
         tick_s_q  <= tick_s_d;
      end
   end

   assign tick_1us_o = tick_us_q;
   assign tick_1ms_o = tick_ms_q;
   assign tick_1s_o  = tick_s_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .iClk      (iClk),
         .resetn_i  (resetn_i),
         .tick_us_i (tick_us_q),
         .tick_ms_i (tick_ms_q),
         .start_i   (ch_start_i[k]),
         .stop_i    (ch_stop_i[k]),
         .mode_i    (ch_mode_i[k]),
         .base_i    (ch_base_i[k]),
         .period_i  (ch_period_i[k*CNT_W +: CNT_W]),
         .busy_o    (ch_busy_o[k]),
         .expire_o  (ch_expire_o[k])
      );
   end
endmodule

// File: tb/tb_tick_timer_array.sv
// Scoreboard bench: stimulus pushes expected expire cycles, a monitor pops them
// on every ch_expire_o pulse and checks the strobes against a cycle-count model.
module tb_tick_timer_array;
   localparam int CLK   = 2;
   localparam int NCH   = 4;
   localparam int CW    = 10;
   localparam int US_C  = CLK;
   localparam int MS_C  = CLK * 1000;

   logic            iClk = 1'b0;
   logic            resetn;
   logic            tick_1us, tick_1ms, tick_1s;
   logic [NCH-1:0]  ch_start, ch_stop, ch_mode, ch_base, ch_busy, ch_expire;
   logic [NCH*CW-1:0] ch_period;

   typedef struct {int ch; int cyc;} exp_t;
   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   tick_timer_array #(.CLK_PER_US(CLK), .NUM_CH(NCH), .CNT_W(CW)) dut (
      .iClk(iClk), .resetn_i(resetn),
      .tick_1us_o(tick_1us), .tick_1ms_o(tick_1ms), .tick_1s_o(tick_1s),
      .ch_start_i(ch_start), .ch_stop_i(ch_stop), .ch_mode_i(ch_mode),
      .ch_base_i(ch_base), .ch_period_i(ch_period),
      .ch_busy_o(ch_busy), .ch_expire_o(ch_expire)
   );

   always #5 iClk = ~iClk;

   // edges since reset release; after edge k the negedge sees cyc == k
   always @(posedge iClk or negedge resetn)
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // expire visible at cycle of the p-th tick counted strictly after start edge s
   function automatic int exp_cyc(input int s, input int unit, input int p);
      int m;
      m = (s + unit - 1) / unit;
      if (m < 1) m = 1;
      return m * unit + 1 + (p - 1) * unit;
   endfunction

   always @(negedge iClk) begin
      if (resetn) begin
         chk("tick_1us", tick_1us, (cyc > 0) && (cyc % US_C == 0));
         chk("tick_1ms", tick_1ms, (cyc > 0) && (cyc % MS_C == 0));
         chk("tick_1s",  tick_1s, 0);
         for (int i = sb_q.size() - 1; i >= 0; i--)
            if (sb_q[i].cyc < cyc) begin
               chk($sformatf("expire_missed_ch%0d", sb_q[i].ch), cyc, sb_q[i].cyc);
               sb_q.delete(i);
            end
         for (int k = 0; k < NCH; k++)
            if (ch_expire[k]) begin
               int idx;
               idx = -1;
               for (int i = 0; i < sb_q.size(); i++)
                  if (sb_q[i].ch == k && (idx < 0 || sb_q[i].cyc < sb_q[idx].cyc)) idx = i;
               if (idx < 0) chk($sformatf("expire_unexpected_ch%0d", k), cyc, -1);
               else begin
                  chk($sformatf("expire_cycle_ch%0d", k), cyc, sb_q[idx].cyc);
                  sb_q.delete(idx);
               end
            end
      end
   end

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 30000) begin
         @(negedge iClk);
         guard++;
      end
      if (cyc < target) chk("wait_timeout", cyc, target);
   endtask

   // all drive tasks are entered at a negedge and return at the next one
   task automatic start_ch(input int ch, input logic mode, input logic base,
                           input int p, input bit push, output int x);
      int s;
      s = cyc + 1;
      ch_start[ch] = 1'b1;
      ch_mode[ch]  = mode;
      ch_base[ch]  = base;
      ch_period[ch*CW +: CW] = p[CW-1:0];
      x = exp_cyc(s, base ? MS_C : US_C, p);
      if (push) sb_q.push_back('{ch, x});
      @(negedge iClk);
      ch_start[ch] = 1'b0;
      chk($sformatf("busy_after_start_ch%0d", ch), ch_busy[ch], p != 0);
   endtask

   task automatic stop_ch(input int ch, input bit with_start);
      ch_stop[ch]  = 1'b1;
      ch_start[ch] = with_start;
      ch_period[ch*CW +: CW] = CW'(4);
      @(negedge iClk);
      ch_stop[ch]  = 1'b0;
      ch_start[ch] = 1'b0;
      chk($sformatf("busy_after_stop_ch%0d", ch), ch_busy[ch], 0);
   endtask

   initial begin
      int x, x1, xa, xb, xc, xd, s;
      resetn    = 1'b0;
      ch_start  = '0;
      ch_stop   = '0;
      ch_mode   = '0;
      ch_base   = '0;
      ch_period = '0;
      repeat (3) @(negedge iClk);
      chk("reset_ticks",  {tick_1us, tick_1ms, tick_1s}, 0);
      chk("reset_busy",   ch_busy, 0);
      chk("reset_expire", ch_expire, 0);
      resetn = 1'b1;
      repeat (3) @(negedge iClk);

      // one-shot us period 5
      start_ch(0, 1'b0, 1'b0, 5, 1, x);
      wait_until(x);
      chk("oneshot_busy_fall", ch_busy[0], 0);
      repeat (20) @(negedge iClk);

      // period 0 ignored
      start_ch(0, 1'b0, 1'b0, 0, 0, x);
      repeat (4) @(negedge iClk);
      chk("period0_busy", ch_busy[0], 0);

      // stop+start together, idle and running
      stop_ch(3, 1);
      start_ch(3, 1'b1, 1'b0, 4, 0, x);
      stop_ch(3, 1);

      // restart mid-run: only the new period may expire
      start_ch(2, 1'b0, 1'b0, 20, 0, x);
      repeat (10) @(negedge iClk);
      start_ch(2, 1'b0, 1'b0, 10, 1, x);
      wait_until(x + 60);
      chk("restart_busy_done", ch_busy[2], 0);

      // stop coinciding with the terminal tick
      start_ch(0, 1'b0, 1'b0, 3, 0, x);
      wait_until(x - 1);
      stop_ch(0, 0);
      repeat (20) @(negedge iClk);

      // concurrency: periods 1,2,3,1 us in the same cycle
      s = cyc + 1;
      ch_start  = 4'hF;
      ch_mode   = 4'h0;
      ch_base   = 4'h0;
      ch_period = {CW'(1), CW'(3), CW'(2), CW'(1)};
      xa = exp_cyc(s, US_C, 1); xb = exp_cyc(s, US_C, 2);
      xc = exp_cyc(s, US_C, 3); xd = exp_cyc(s, US_C, 1);
      sb_q.push_back('{0, xa}); sb_q.push_back('{1, xb});
      sb_q.push_back('{2, xc}); sb_q.push_back('{3, xd});
      @(negedge iClk);
      ch_start = '0;
      chk("concurrent_busy", ch_busy, 4'hF);
      wait_until(xc + 10);
      chk("concurrent_idle", ch_busy, 0);

      // max period, no wrap
      start_ch(1, 1'b0, 1'b0, (1 << CW) - 1, 1, x);
      wait_until(x);
      chk("maxperiod_busy_fall", ch_busy[1], 0);
      repeat (100) @(negedge iClk);

      // periodic ms period 3, then stop
      start_ch(1, 1'b1, 1'b1, 3, 0, x1);
      sb_q.push_back('{1, x1});
      sb_q.push_back('{1, x1 + 3 * MS_C});
      wait_until(x1 + 3 * MS_C + 10);
      chk("periodic_still_busy", ch_busy[1], 1);
      stop_ch(1, 0);
      wait_until(x1 + 6 * MS_C + 20);

      // asynchronous reset mid-run
      start_ch(0, 1'b1, 1'b0, 7, 0, x);
      start_ch(3, 1'b1, 1'b0, 9, 0, x);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_busy",   ch_busy, 0);
      chk("async_rst_expire", ch_expire, 0);
      chk("async_rst_ticks",  {tick_1us, tick_1ms, tick_1s}, 0);
      @(negedge iClk);
      resetn = 1'b1;
      repeat (8) @(negedge iClk);
      chk("post_rst_busy", ch_busy, 0);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
